// File: rtl/led_fade_pwm.sv
// LED driver for the ROM-pattern chain: per-LED linear PWM brightness fade toward the
// registered pattern bit, or a registered pass-through when fading is disabled.
module led_fade_pwm #(
  parameter int unsigned PWM_W    = 4,
  parameter int unsigned STEP_DIV = 1000
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       fade_en,
  input  logic [7:0] pattern,
  output logic [7:0] LED,
  output logic       busy
);

  localparam int unsigned SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PWM_W-1:0] MAX       = '1;
  localparam logic [PWM_W-1:0] ONE       = PWM_W'(1);
  localparam logic [SW-1:0]    STEP_LAST = SW'(STEP_DIV - 1);
  localparam logic [SW-1:0]    STEP_ONE  = SW'(1);

  logic [7:0]       pat_q;
  logic [PWM_W-1:0] pwm_cnt;
  logic [SW-1:0]    step_cnt;
  logic             step_tick;
  logic [7:0]       led_d;
  logic [7:0]       neq;

  assign step_tick = (step_cnt == STEP_LAST);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      pat_q    <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
      LED      <= '0;
    end else begin
      pat_q    <= pattern;
      pwm_cnt  <= pwm_cnt + ONE;
      step_cnt <= step_tick ? '0 : step_cnt + STEP_ONE;
      LED      <= led_d;
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_led
    logic [PWM_W-1:0] level;
    logic [PWM_W-1:0] tgt;

    assign tgt = pat_q[i] ? MAX : '0;

    // Target is always 0 or MAX, so stepping toward it can never wrap.
    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        level <= '0;
      end else if (!fade_en) begin
        level <= tgt;
      end else if (step_tick) begin
        if (level < tgt) begin
          level <= level + ONE;
        end else if (level > tgt) begin
          level <= level - ONE;
        end
      end
    end

    assign led_d[i] = fade_en ? ((level == MAX) | (level > pwm_cnt)) : pat_q[i];
    assign neq[i]   = (level != tgt);
  end

  assign busy = fade_en & (|neq);

endmodule

// File: tb/tb_led_fade_pwm.sv
// Self-checking bench for led_fade_pwm: a cycle-count based reference model for a STEP_DIV=4
// and a STEP_DIV=1 instance sharing stimulus, plus directed scenarios with literal expectations.
module tb_led_fade_pwm;

  localparam int unsigned PWM_W = 4;
  localparam int unsigned DIV_A = 4;
  localparam int          MAXL  = 15;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       fade_en = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [7:0] led_a, led_b;
  logic       busy_a, busy_b;

  int n_checks = 0;
  int n_fail   = 0;

  led_fade_pwm #(.PWM_W(PWM_W), .STEP_DIV(DIV_A)) u_dut_a (
    .CLK(CLK), .RESET(RESET), .fade_en(fade_en), .pattern(pattern), .LED(led_a), .busy(busy_a)
  );

  led_fade_pwm #(.PWM_W(PWM_W), .STEP_DIV(1)) u_dut_b (
    .CLK(CLK), .RESET(RESET), .fade_en(fade_en), .pattern(pattern), .LED(led_b), .busy(busy_b)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: t counts clock edges since reset release, so the PWM phase is t mod 16
  // and a brightness step happens on edges where t mod STEP_DIV == STEP_DIV-1.
  int         t;
  logic [7:0] m_pat [2];
  logic [7:0] m_led [2];
  int         m_lvl [2][8];

  always @(posedge CLK or posedge RESET) begin : model
    int         div;
    bit         tick;
    int         tg;
    logic [7:0] nl;
    if (RESET) begin
      t <= 0;
      for (int d = 0; d < 2; d++) begin
        m_pat[d] <= 8'h00;
        m_led[d] <= 8'h00;
        for (int i = 0; i < 8; i++) m_lvl[d][i] <= 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        div  = (d == 0) ? int'(DIV_A) : 1;
        tick = ((t % div) == div - 1);
        for (int i = 0; i < 8; i++) begin
          tg    = m_pat[d][i] ? MAXL : 0;
          nl[i] = fade_en ? ((m_lvl[d][i] == MAXL) || (m_lvl[d][i] > (t % 16))) : m_pat[d][i];
          if (!fade_en) m_lvl[d][i] <= tg;
          else if (tick && m_lvl[d][i] < tg) m_lvl[d][i] <= m_lvl[d][i] + 1;
          else if (tick && m_lvl[d][i] > tg) m_lvl[d][i] <= m_lvl[d][i] - 1;
        end
        m_led[d] <= nl;
        m_pat[d] <= pattern;
      end
      t <= t + 1;
    end
  end

  function automatic logic model_busy(input int d);
    logic b = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (m_lvl[d][i] != (m_pat[d][i] ? MAXL : 0)) b = 1'b1;
    end
    return fade_en & b;
  endfunction

  always @(negedge CLK) begin
    chk("led_a", 32'(led_a), 32'(m_led[0]));
    chk("busy_a", 32'(busy_a), 32'(model_busy(0)));
    chk("led_b", 32'(led_b), 32'(m_led[1]));
    chk("busy_b", 32'(busy_b), 32'(model_busy(1)));
  end

  // Leaves the bench 2 time units after a rising edge, where inputs are changed.
  task automatic cyc(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  // After this returns, the next rising edge is the first edge after release (t = 0).
  task automatic do_reset(input logic f, input logic [7:0] p);
    RESET   = 1'b1;
    fade_en = f;
    pattern = p;
    cyc(2);
    RESET = 1'b0;
  endtask

  int   cnt_a, cnt_b;
  logic bad;
  logic [7:0] hi_or;

  initial begin
    // Bypass path: 2-clock latency, never busy.
    do_reset(1'b0, 8'h00);
    chk("reset_led", 32'(led_a), 32'h0);
    chk("reset_busy", 32'(busy_a), 32'h0);
    cyc(3);
    pattern = 8'hA5;
    cyc(1);
    chk("bypass_lat1", 32'(led_a), 32'h00);
    cyc(1);
    chk("bypass_a5", 32'(led_a), 32'hA5);
    chk("bypass_a5_b", 32'(led_b), 32'hA5);
    pattern = 8'h3C;
    cyc(1);
    chk("bypass_hold", 32'(led_a), 32'hA5);
    cyc(1);
    chk("bypass_3c", 32'(led_a), 32'h3C);
    chk("bypass_busy", 32'(busy_a), 32'h0);

    // Async reset mid-ramp at level 9 (after edge 35), between clock edges.
    do_reset(1'b1, 8'h01);
    cyc(37);
    RESET = 1'b1;
    #1;
    chk("async_led", 32'(led_a), 32'h0);
    chk("async_busy", 32'(busy_a), 32'h0);
    chk("async_led_b", 32'(led_b), 32'h0);
    cyc(1);
    RESET = 1'b0;

    // Ramp restarts from 0: busy for 59 sampled cycles (A), 15 (B); LED[0] solid afterwards.
    cnt_a = 0; cnt_b = 0; bad = 1'b0; hi_or = 8'h00;
    for (int k = 0; k <= 80; k++) begin
      @(negedge CLK);
      cnt_a += int'(busy_a);
      cnt_b += int'(busy_b);
      hi_or |= led_a & 8'hFE;
      if (k >= 61 && led_a[0] !== 1'b1) bad = 1'b1;
    end
    chk("ramp_busy_cycles", 32'(cnt_a), 32'd59);
    chk("ramp_busy_cycles_b", 32'(cnt_b), 32'd15);
    chk("ramp_others_dark", 32'(hi_or), 32'h0);
    chk("ramp_full_lit", 32'(bad), 32'h0);
    chk("model_full_level", 32'(m_lvl[0][0]), 32'd15);
    cyc(1);

    // Reversal at level 6 (after edge 23): 24 busy cycles back down, then dark.
    do_reset(1'b1, 8'h01);
    cyc(24);
    pattern = 8'h00;
    cnt_a = 0; cnt_b = 0; bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      cnt_a += int'(busy_a);
      cnt_b += int'(busy_b);
      if (k >= 25 && led_a[0] !== 1'b0) bad = 1'b1;
    end
    chk("rev_busy_cycles", 32'(cnt_a), 32'd24);
    chk("rev_busy_cycles_b", 32'(cnt_b), 32'd15);
    chk("rev_dark", 32'(bad), 32'h0);
    cyc(1);

    // Mode switch at level 7: snap to full, busy stays low after re-enable.
    do_reset(1'b1, 8'hFF);
    cyc(29);
    chk("mode_busy_before", 32'(busy_a), 32'h1);
    fade_en = 1'b0;
    #1;
    chk("mode_busy_drop", 32'(busy_a), 32'h0);
    cyc(1);
    chk("mode_led", 32'(led_a), 32'hFF);
    fade_en = 1'b1;
    #1;
    chk("mode_reen_busy", 32'(busy_a), 32'h0);
    cyc(1);
    chk("mode_reen_led", 32'(led_a), 32'hFF);
    chk("mode_reen_busy2", 32'(busy_a), 32'h0);

    // STEP_DIV=1 corner: busy high exactly 15 cycles.
    do_reset(1'b1, 8'h80);
    cnt_b = 0;
    for (int k = 0; k < 24; k++) begin
      @(negedge CLK);
      cnt_b += int'(busy_b);
    end
    chk("div1_busy_cycles", 32'(cnt_b), 32'd15);
    chk("div1_led", 32'(led_b), 32'h80);
    cyc(1);

    // Random traffic against the model.
    do_reset(1'b1, 8'h00);
    for (int k = 0; k < 3000; k++) begin
      cyc(1);
      if ($urandom_range(49) == 0) pattern = 8'($urandom);
      if ($urandom_range(299) == 0) fade_en = ~fade_en;
      if ($urandom_range(1499) == 0) begin
        RESET = 1'b1;
        #1;
        RESET = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
